// File: rtl/aib_adapt_pkg.sv
// Shared definitions for the AIB adapter TX channel gearbox.
// Mode encodings, FSM state type and ratio helper.
package aib_adapt_pkg;

  localparam int DW_DEF   = 80;
  localparam int MAXR_DEF = 4;

  localparam logic [1:0] MODE_1TO1 = 2'b00;
  localparam logic [1:0] MODE_2TO1 = 2'b01;
  localparam logic [1:0] MODE_4TO1 = 2'b10;
  localparam logic [1:0] MODE_REG  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } gbx_state_t;

  // Index of the last beat of a word (ratio - 1).
  function automatic logic [1:0] last_pos(input logic [1:0] m);
    case (m)
      MODE_2TO1: return 2'd1;
      MODE_4TO1: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/aib_adapt_sfifo.sv
// Synchronous queue holding whole wide words.
// Read data is the head entry, valid whenever not empty.
module aib_adapt_sfifo
  import aib_adapt_pkg::*;
#(
  parameter int W     = DW_DEF * MAXR_DEF,
  parameter int DEPTH = 4,
  localparam int FW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [FW-1:0] fill,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (fill == FW'(DEPTH));
  assign empty   = (fill == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      fill <= fill + FW'(do_push) - FW'(do_pop);
    end
  end

endmodule

// File: rtl/aib_adapt_txchnl_gbx.sv
// TX channel gearbox: queues wide words and serialises them
// into 1/2/4 beats, with marker, swap and register bypass.
module aib_adapt_txchnl_gbx
  import aib_adapt_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int MAXR  = MAXR_DEF,
  parameter int DEPTH = 4,
  parameter int MKW   = 7,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_wm_en,
  input  logic [MKW-1:0]     cfg_mkbit,
  input  logic               cfg_swap_en,
  input  logic [DW*MAXR-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [DW-1:0]      dout,
  output logic               dout_valid,
  output logic               ovf_sticky,
  output logic               unf_sticky,
  output logic [FW-1:0]      fill
);

  gbx_state_t          state;
  logic [1:0]          cnt;
  logic [1:0]          sh_mode;
  logic                sh_wm;
  logic                sh_swap;
  logic [MKW-1:0]      sh_mk;

  logic                idle;
  logic [1:0]          mode;
  logic                wm;
  logic                swap;
  logic [MKW-1:0]      mk;
  logic                byp;
  logic [1:0]          lastp;
  logic                wrap;
  logic [1:0]          np;
  logic [1:0]          sel;
  logic                load;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [DW*MAXR-1:0]  head;
  logic [DW-1:0]       beat;

  aib_adapt_sfifo #(
    .W     (DW * MAXR),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (head),
    .fill  (fill),
    .full  (full),
    .empty (empty)
  );

  // Live config in IDLE, frozen shadow copy while a stream runs.
  always_comb begin
    idle  = (state == ST_IDLE);
    mode  = idle ? cfg_mode    : sh_mode;
    wm    = idle ? cfg_wm_en   : sh_wm;
    swap  = idle ? cfg_swap_en : sh_swap;
    mk    = idle ? cfg_mkbit   : sh_mk;
    byp   = idle & (mode == MODE_REG);
    lastp = last_pos(mode);
    wrap  = ~idle & (cnt == lastp);
    np    = (idle | wrap) ? 2'd0 : cnt + 2'd1;
    load  = idle ? (~byp & ~empty) : (~wrap | ~empty);
    pop   = load & (np == lastp);
    sel   = (swap && lastp == 2'd1) ? {1'b0, ~np[0]} : np;
    beat  = head[int'(sel)*DW +: DW];
    if (wm && lastp != 2'd0 && int'(mk) < DW)
      beat[mk] = (np == 2'd0);
  end

  assign din_ready = ~rst & (byp | ~full);
  assign push      = din_valid & din_ready & ~byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      sh_mode    <= MODE_1TO1;
      sh_wm      <= 1'b0;
      sh_swap    <= 1'b0;
      sh_mk      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (din_valid & ~din_ready) ovf_sticky <= 1'b1;
      if (idle) begin
        sh_mode <= cfg_mode;
        sh_wm   <= cfg_wm_en;
        sh_swap <= cfg_swap_en;
        sh_mk   <= cfg_mkbit;
      end
      if (byp) begin
        dout       <= din[DW-1:0];
        dout_valid <= din_valid;
      end else if (load) begin
        dout       <= beat;
        dout_valid <= 1'b1;
        cnt        <= np;
        state      <= ST_RUN;
      end else begin
        dout       <= '0;
        dout_valid <= 1'b0;
        cnt        <= 2'd0;
        state      <= ST_IDLE;
        // A word arriving this edge means the stream did not starve.
        if (wrap & ~din_valid) unf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aib_adapt_txchnl_gbx.sv
// Directed bench for the TX channel gearbox.
// Expected beats are queued at push time and popped on output.
module tb_aib_adapt_txchnl_gbx;

  localparam int DW    = 80;
  localparam int MAXR  = 4;
  localparam int DEPTH = 4;
  localparam int MKW   = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         cfg_mode;
  logic               cfg_wm_en;
  logic [MKW-1:0]     cfg_mkbit;
  logic               cfg_swap_en;
  logic [DW*MAXR-1:0] din;
  logic               din_valid;
  logic               din_ready;
  logic [DW-1:0]      dout;
  logic               dout_valid;
  logic               ovf_sticky;
  logic               unf_sticky;
  logic [2:0]         fill;

  logic [DW-1:0] sb [$];
  int            n_assert = 0;
  int            n_fail   = 0;
  bit            byp_chk  = 1'b0;

  aib_adapt_txchnl_gbx #(
    .DW(DW), .MAXR(MAXR), .DEPTH(DEPTH), .MKW(MKW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_mode    (cfg_mode),
    .cfg_wm_en   (cfg_wm_en),
    .cfg_mkbit   (cfg_mkbit),
    .cfg_swap_en (cfg_swap_en),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .ovf_sticky  (ovf_sticky),
    .unf_sticky  (unf_sticky),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*MAXR-1:0] rnd_word();
    logic [DW*MAXR-1:0] w;
    for (int i = 0; i < DW * MAXR / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic void push_beats(input logic [DW*MAXR-1:0] w);
    int r;
    r = (cfg_mode == 2'b00) ? 1 : (cfg_mode == 2'b01) ? 2 : 4;
    for (int p = 0; p < r; p++) begin
      int s;
      logic [DW-1:0] b;
      s = (cfg_swap_en && r == 2) ? 1 - p : p;
      b = w[s*DW +: DW];
      if (cfg_wm_en && r > 1) b[cfg_mkbit] = (p == 0);
      sb.push_back(b);
    end
  endfunction

  task automatic cyc(output bit acc);
    #1;
    acc = din_valid && din_ready;
    if (acc && cfg_mode != 2'b11) push_beats(din);
    @(posedge clk);
    #1;
    if (!byp_chk && dout_valid === 1'b1) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat got=%h exp=none", dout);
      end
      if (sb.size() != 0) check("beat", dout, sb.pop_front());
    end
  endtask

  task automatic tick();
    bit a;
    cyc(a);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, DW'(sb.size()), '0);
    tick();
    check({tag, "_idle_valid"}, DW'(dout_valid), '0);
    check({tag, "_idle_fill"}, DW'(fill), '0);
  endtask

  initial begin
    logic [DW*MAXR-1:0] w;
    logic [DW-1:0]      mk79;
    logic [DW-1:0]      pd;
    logic               pv;
    bit                 acc;
    bit                 saw_full;
    int                 n;

    mk79        = '0;
    mk79[79]    = 1'b1;
    rst         = 1'b1;
    cfg_mode    = 2'b00;
    cfg_wm_en   = 1'b0;
    cfg_mkbit   = '0;
    cfg_swap_en = 1'b0;
    din         = '0;
    din_valid   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", DW'(din_ready), '0);
    check("rst_dout", dout, '0);
    check("rst_valid", DW'(dout_valid), '0);
    check("rst_fill", DW'(fill), '0);
    check("rst_ovf", DW'(ovf_sticky), '0);
    check("rst_unf", DW'(unf_sticky), '0);
    rst = 1'b0;
    #1;
    check("rel_ready", DW'(din_ready), 80'd1);

    // 1:1, three back-to-back words
    cfg_mode  = 2'b00;
    din       = rnd_word();
    din_valid = 1'b1;
    tick();
    check("m0_lat", DW'(dout_valid), '0);
    din = rnd_word();
    tick();
    check("m0_v1", DW'(dout_valid), 80'd1);
    din = rnd_word();
    tick();
    check("m0_v2", DW'(dout_valid), 80'd1);
    din_valid = 1'b0;
    tick();
    check("m0_v3", DW'(dout_valid), 80'd1);
    check("m0_fill", DW'(fill), '0);
    tick();
    check("m0_end", DW'(dout_valid), '0);
    check("m0_unf", DW'(unf_sticky), 80'd1);
    check("m0_sb", DW'(sb.size()), '0);

    // 4:1 with marker, reset during the second beat
    cfg_mode  = 2'b10;
    cfg_wm_en = 1'b1;
    cfg_mkbit = 7'd79;
    din       = rnd_word();
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mr_dout", dout, '0);
    check("mr_valid", DW'(dout_valid), '0);
    check("mr_fill", DW'(fill), '0);
    check("mr_ovf", DW'(ovf_sticky), '0);
    check("mr_unf", DW'(unf_sticky), '0);
    sb.delete();
    rst = 1'b0;
    tick();
    check("mr_no_partial", DW'(dout_valid), '0);
    din       = '0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check("mk_first", dout, mk79);
    tick();
    check("mk_second", dout, '0);
    drain("m10");
    check("m10_unf", DW'(unf_sticky), 80'd1);

    // 2:1 swap with marker on bit 5
    cfg_mode    = 2'b01;
    cfg_swap_en = 1'b1;
    cfg_mkbit   = 7'd5;
    w           = rnd_word();
    w[79:0]     = {10{8'h22}};
    w[159:80]   = {10{8'h11}};
    din         = w;
    din_valid   = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check("sw_first", dout, {{9{8'h11}}, 8'h31});
    tick();
    check("sw_second", dout, {{9{8'h22}}, 8'h02});
    drain("m01");

    // 4:1 backpressure: six words through a four-entry queue
    cfg_mode    = 2'b10;
    cfg_wm_en   = 1'b0;
    cfg_swap_en = 1'b0;
    saw_full    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din       = rnd_word();
      din_valid = 1'b1;
      acc       = 1'b0;
      n         = 0;
      while (!acc && n < 40) begin
        cyc(acc);
        if (fill == 3'd4 && din_ready == 1'b0) saw_full = 1'b1;
        n++;
      end
      check("bp_acc", DW'(acc), 80'd1);
    end
    din_valid = 1'b0;
    drain("bp");
    check("bp_full_seen", DW'(saw_full), 80'd1);
    check("bp_ovf", DW'(ovf_sticky), 80'd1);

    // Register bypass
    cfg_mode = 2'b11;
    byp_chk  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w         = rnd_word();
      w[79:0]   = {5{16'hABCD}} ^ 80'(i);
      din       = w;
      din_valid = (i % 3) != 1;
      pd        = w[79:0];
      pv        = din_valid;
      #1;
      check("byp_ready", DW'(din_ready), 80'd1);
      tick();
      check("byp_dout", dout, pd);
      check("byp_valid", DW'(dout_valid), DW'(pv));
      check("byp_fill", DW'(fill), '0);
    end
    din_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
